// File: rtl/speed_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// speed_ramp_ctrl
//
// Line-following drive speed controller. A registered mode (HALT / SLOW / FAST)
// is chosen from the count of black lines passed and the drive enable. From
// the mode and the per-wheel switch trims it derives a target speed for each
// wheel, and it drives registered wheel speeds toward those targets.
//
// Optional feature, selected with the macro SPEED_RAMP_EN:
//   defined   : outputs are slew-limited. A tick fires once every TICK_DIV
//               clocks, and on each tick each wheel moves at most RAMP_STEP
//               toward its target.
//   undefined : there is no tick counter and each wheel loads its target on
//               every clock.
//
// Ports
//   clk       in   1      single clock
//   rst       in   1      synchronous, active-high reset
//   en        in   1      drive enable; low forces mode HALT (targets 0)
//   lin       in   SEG_W  count of black lines passed
//   sw_l_val  in   5      left wheel trim
//   sw_r_val  in   5      right wheel trim
//   pwm_l     out  PWM_W  registered left wheel speed
//   pwm_r     out  PWM_W  registered right wheel speed
//   mode      out  2      registered mode / FSM state: 00 HALT, 01 SLOW, 10 FAST
//   settled   out  1      both wheel speeds equal their current targets
//
// There is no handshake on this block. Inputs are sampled on every clock, and
// outputs are valid on every clock.
// -----------------------------------------------------------------------------
module speed_ramp_ctrl #(
  parameter int PWM_W      = 32,
  parameter int SEG_W      = 32,
  parameter int FAST_BASE  = 500,
  parameter int SLOW_BASE  = 150,
  parameter int TRIM_GAIN  = 5,
  parameter int SLOW_SEG_A = 3,
  parameter int SLOW_SEG_B = 9,
  parameter int END_SEG    = 12,
  parameter int RAMP_STEP  = 50,
  parameter int TICK_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEG_W-1:0] lin,
  input  logic [4:0]       sw_l_val,
  input  logic [4:0]       sw_r_val,
  output logic [PWM_W-1:0] pwm_l,
  output logic [PWM_W-1:0] pwm_r,
  output logic [1:0]       mode,
  output logic             settled
);

  // Reject parameter sets that would stall the ramp or the tick counter.
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("speed_ramp_ctrl: TICK_DIV must be at least 1");
  end
  if (RAMP_STEP < 1) begin : g_bad_ramp_step
    $error("speed_ramp_ctrl: RAMP_STEP must be at least 1");
  end

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_FAST = 2'b10
  } mode_t;

  localparam logic [SEG_W-1:0] SEG_A_V   = SEG_W'(SLOW_SEG_A);
  localparam logic [SEG_W-1:0] SEG_B_V   = SEG_W'(SLOW_SEG_B);
  localparam logic [SEG_W-1:0] SEG_END_V = SEG_W'(END_SEG);
  localparam logic [PWM_W-1:0] FAST_V    = PWM_W'(FAST_BASE);
  localparam logic [PWM_W-1:0] SLOW_V    = PWM_W'(SLOW_BASE);
  localparam logic [PWM_W-1:0] GAIN_V    = PWM_W'(TRIM_GAIN);

  mode_t            mode_q;
  mode_t            mode_d;
  logic [PWM_W-1:0] target_l;
  logic [PWM_W-1:0] target_r;
  logic [PWM_W-1:0] base;
  logic [PWM_W-1:0] trim_l;
  logic [PWM_W-1:0] trim_r;
  logic             halt;

  // ---------------------------------------------------------------------------
  // Mode FSM: the state register re-evaluates on every clock. The disable and
  // end-of-course conditions take priority over the slow segments.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_HALT;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = MODE_FAST;
    if (!en) begin
      mode_d = MODE_HALT;
    end else if (lin >= SEG_END_V) begin
      mode_d = MODE_HALT;
    end else if ((lin == SEG_A_V) || (lin == SEG_B_V)) begin
      mode_d = MODE_SLOW;
    end
  end

  assign mode = mode_q;

  // ---------------------------------------------------------------------------
  // Targets follow the registered mode, so a trim change retargets the wheels
  // directly without passing through a mode transition.
  // ---------------------------------------------------------------------------
  assign trim_l = PWM_W'(sw_l_val) * GAIN_V;
  assign trim_r = PWM_W'(sw_r_val) * GAIN_V;

  always_comb begin
    base = '0;
    halt = 1'b1;
    unique case (mode_q)
      MODE_FAST: begin
        base = FAST_V;
        halt = 1'b0;
      end
      MODE_SLOW: begin
        base = SLOW_V;
        halt = 1'b0;
      end
      default: begin
        base = '0;
        halt = 1'b1;
      end
    endcase
  end

  assign target_l = halt ? '0 : (base + trim_l);
  assign target_r = halt ? '0 : (base + trim_r);

  assign settled = (pwm_l == target_l) && (pwm_r == target_r);

`ifdef SPEED_RAMP_EN
  // ---------------------------------------------------------------------------
  // Slew-limited outputs. The tick counter runs freely from reset, so a
  // retarget mid-ramp is picked up on the next tick without restarting the
  // tick phase.
  // ---------------------------------------------------------------------------
  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [PWM_W-1:0] STEP_V   = PWM_W'(RAMP_STEP);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  assign tick = (tick_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // One slew step toward tgt. Each direction is tested against the remaining
  // distance before stepping, so the result can neither pass the target nor
  // drop below zero (the target itself is never negative).
  function automatic logic [PWM_W-1:0] slew(input logic [PWM_W-1:0] cur,
                                            input logic [PWM_W-1:0] tgt);
    logic [PWM_W-1:0] res;
    if (tgt >= cur) begin
      res = ((tgt - cur) <= STEP_V) ? tgt : (cur + STEP_V);
    end else begin
      res = ((cur - tgt) <= STEP_V) ? tgt : (cur - STEP_V);
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_l <= '0;
      pwm_r <= '0;
    end else if (tick) begin
      pwm_l <= slew(pwm_l, target_l);
      pwm_r <= slew(pwm_r, target_r);
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Unlimited outputs: each wheel follows its target one clock behind the mode.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_l <= '0;
      pwm_r <= '0;
    end else begin
      pwm_l <= target_l;
      pwm_r <= target_r;
    end
  end
`endif

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_speed_ramp_ctrl
//
// Directed bench for speed_ramp_ctrl with default parameters. Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge. The
// scenarios are chosen at compile time to match the build: the slew-limited
// scenarios run when SPEED_RAMP_EN is defined, and the direct-load scenarios
// run otherwise.
// -----------------------------------------------------------------------------
module tb_speed_ramp_ctrl;

  localparam int PWM_W    = 32;
  localparam int SEG_W    = 32;
  localparam int TICK_DIV = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic [SEG_W-1:0] lin;
  logic [4:0]       sw_l_val;
  logic [4:0]       sw_r_val;
  logic [PWM_W-1:0] pwm_l;
  logic [PWM_W-1:0] pwm_r;
  logic [1:0]       mode;
  logic             settled;

  int checks = 0;
  int errors = 0;
  int phase  = 0;  // expected tick-counter value, tracked by the bench

  speed_ramp_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .lin      (lin),
    .sw_l_val (sw_l_val),
    .sw_r_val (sw_r_val),
    .pwm_l    (pwm_l),
    .pwm_r    (pwm_r),
    .mode     (mode),
    .settled  (settled)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------- drivers
  // Advance one clock and report whether that edge was a tick edge.
  task automatic step_t(output bit ticked);
    @(posedge clk);
    #1;
    ticked = (phase == TICK_DIV - 1);
    phase  = (phase == TICK_DIV - 1) ? 0 : phase + 1;
  endtask

  task automatic step();
    bit t;
    step_t(t);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst   = 1'b0;
    phase = 0;
  endtask

  task automatic test_reset();
    en = 1'b0; lin = '0; sw_l_val = '0; sw_r_val = '0;
    apply_reset();
    checks++; if (pwm_l !== 32'd0) begin errors++; $display("FAIL reset_pwm_l: got %0d expected 0", pwm_l); end
    checks++; if (pwm_r !== 32'd0) begin errors++; $display("FAIL reset_pwm_r: got %0d expected 0", pwm_r); end
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b expected 00", mode); end
    checks++; if (settled !== 1'b1) begin errors++; $display("FAIL reset_settled: got %b expected 1", settled); end
  endtask

`ifdef SPEED_RAMP_EN
  // Step until a tick edge has been taken; a missing tick counts as an error.
  task automatic next_tick();
    bit t;
    t = 1'b0;
    for (int i = 0; i < TICK_DIV + 1 && !t; i++) step_t(t);
    checks++;
    if (!t) begin errors++; $display("FAIL tick_timeout: got no tick within %0d clocks expected tick", TICK_DIV + 1); end
  endtask

  task automatic test_ramp_up();
    int el, er;
    en = 1'b1; lin = '0; sw_l_val = 5'd2; sw_r_val = 5'd0;
    for (int t = 1; t <= 11; t++) begin
      next_tick();
      el = (50 * t > 510) ? 510 : 50 * t;
      er = (50 * t > 500) ? 500 : 50 * t;
      checks++; if (pwm_l !== PWM_W'(el)) begin errors++; $display("FAIL up_pwm_l t%0d: got %0d expected %0d", t, pwm_l, el); end
      checks++; if (pwm_r !== PWM_W'(er)) begin errors++; $display("FAIL up_pwm_r t%0d: got %0d expected %0d", t, pwm_r, er); end
      checks++; if (settled !== (t == 11)) begin errors++; $display("FAIL up_settled t%0d: got %b expected %b", t, settled, (t == 11)); end
      if (t == 1) begin
        step();
        checks++; if (pwm_l !== 32'd50) begin errors++; $display("FAIL up_hold: got %0d expected 50", pwm_l); end
      end
    end
    checks++; if (mode !== 2'b10) begin errors++; $display("FAIL up_mode: got %b expected 10", mode); end
  endtask

  task automatic test_ramp_slow();
    sw_l_val = 5'd0;
    next_tick();
    checks++; if (pwm_l !== 32'd500) begin errors++; $display("FAIL retrim_pwm_l: got %0d expected 500", pwm_l); end
    lin = 32'd3;
    for (int t = 1; t <= 7; t++) begin
      next_tick();
      checks++; if (pwm_l !== PWM_W'(500 - 50 * t)) begin errors++; $display("FAIL slow_pwm_l t%0d: got %0d expected %0d", t, pwm_l, 500 - 50 * t); end
      checks++; if (settled !== (t == 7)) begin errors++; $display("FAIL slow_settled t%0d: got %b expected %b", t, settled, (t == 7)); end
    end
    checks++; if (mode !== 2'b01) begin errors++; $display("FAIL slow_mode: got %b expected 01", mode); end
  endtask

  task automatic test_ramp_halt();
    lin = 32'd9;
    next_tick();
    checks++; if (mode !== 2'b01) begin errors++; $display("FAIL seg_b_mode: got %b expected 01", mode); end
    checks++; if (pwm_l !== 32'd150) begin errors++; $display("FAIL seg_b_pwm: got %0d expected 150", pwm_l); end
    lin = 32'd12;
    for (int t = 1; t <= 4; t++) begin
      next_tick();
      checks++; if (pwm_l !== PWM_W'((t >= 3) ? 0 : 150 - 50 * t)) begin errors++; $display("FAIL halt_pwm_l t%0d: got %0d expected %0d", t, pwm_l, (t >= 3) ? 0 : 150 - 50 * t); end
    end
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL halt_mode: got %b expected 00", mode); end
  endtask

  task automatic test_en_low();
    lin = '0; en = 1'b1;
    for (int t = 1; t <= 6; t++) next_tick();
    checks++; if (pwm_l !== 32'd300) begin errors++; $display("FAIL en_rise: got %0d expected 300", pwm_l); end
    en = 1'b0;
    step();
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL en_mode: got %b expected 00", mode); end
    for (int t = 1; t <= 6; t++) begin
      next_tick();
      checks++; if (pwm_r !== PWM_W'(300 - 50 * t)) begin errors++; $display("FAIL en_fall t%0d: got %0d expected %0d", t, pwm_r, 300 - 50 * t); end
    end
  endtask

  task automatic test_reset_mid_ramp();
    en = 1'b1; lin = '0;
    for (int t = 1; t <= 7; t++) next_tick();
    checks++; if (pwm_l !== 32'd350) begin errors++; $display("FAIL mid_pre: got %0d expected 350", pwm_l); end
    rst = 1'b1;
    step();
    rst = 1'b0; phase = 0;
    checks++; if (pwm_l !== 32'd0) begin errors++; $display("FAIL mid_pwm: got %0d expected 0", pwm_l); end
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL mid_mode: got %b expected 00", mode); end
    next_tick();
    checks++; if (pwm_l !== 32'd50) begin errors++; $display("FAIL mid_restart: got %0d expected 50", pwm_l); end
  endtask
`else
  task automatic test_fast();
    en = 1'b1; lin = '0; sw_l_val = 5'd31; sw_r_val = 5'd31;
    step();
    checks++; if (mode !== 2'b10) begin errors++; $display("FAIL fast_mode: got %b expected 10", mode); end
    checks++; if (pwm_l !== 32'd0) begin errors++; $display("FAIL fast_latency: got %0d expected 0", pwm_l); end
    checks++; if (settled !== 1'b0) begin errors++; $display("FAIL fast_unsettled: got %b expected 0", settled); end
    step();
    checks++; if (pwm_l !== 32'd655) begin errors++; $display("FAIL fast_pwm_l: got %0d expected 655", pwm_l); end
    checks++; if (pwm_r !== 32'd655) begin errors++; $display("FAIL fast_pwm_r: got %0d expected 655", pwm_r); end
    checks++; if (settled !== 1'b1) begin errors++; $display("FAIL fast_settled: got %b expected 1", settled); end
  endtask

  task automatic test_slow();
    lin = 32'd9;
    step();
    checks++; if (mode !== 2'b01) begin errors++; $display("FAIL slow_b_mode: got %b expected 01", mode); end
    checks++; if (pwm_l !== 32'd655) begin errors++; $display("FAIL slow_b_hold: got %0d expected 655", pwm_l); end
    step();
    checks++; if (pwm_l !== 32'd305) begin errors++; $display("FAIL slow_b_pwm_l: got %0d expected 305", pwm_l); end
    checks++; if (pwm_r !== 32'd305) begin errors++; $display("FAIL slow_b_pwm_r: got %0d expected 305", pwm_r); end
    lin = 32'd3; sw_l_val = 5'd2; sw_r_val = 5'd7;
    #1;
    checks++; if (settled !== 1'b0) begin errors++; $display("FAIL slow_a_retarget: got %b expected 0", settled); end
    step();
    checks++; if (mode !== 2'b01) begin errors++; $display("FAIL slow_a_mode: got %b expected 01", mode); end
    checks++; if (pwm_l !== 32'd160) begin errors++; $display("FAIL slow_a_pwm_l: got %0d expected 160", pwm_l); end
    checks++; if (pwm_r !== 32'd185) begin errors++; $display("FAIL slow_a_pwm_r: got %0d expected 185", pwm_r); end
  endtask

  task automatic test_retrim();
    lin = '0;
    step();
    step();
    checks++; if (pwm_l !== 32'd510) begin errors++; $display("FAIL trim_pwm_l: got %0d expected 510", pwm_l); end
    checks++; if (pwm_r !== 32'd535) begin errors++; $display("FAIL trim_pwm_r: got %0d expected 535", pwm_r); end
    sw_l_val = 5'd10;
    #1;
    checks++; if (settled !== 1'b0) begin errors++; $display("FAIL trim_unsettled: got %b expected 0", settled); end
    step();
    checks++; if (pwm_l !== 32'd550) begin errors++; $display("FAIL trim_new_l: got %0d expected 550", pwm_l); end
    checks++; if (mode !== 2'b10) begin errors++; $display("FAIL trim_mode: got %b expected 10", mode); end
  endtask

  task automatic test_halt_boundary();
    lin = 32'd11;
    step();
    checks++; if (mode !== 2'b10) begin errors++; $display("FAIL lin11_mode: got %b expected 10", mode); end
    lin = 32'd12;
    step();
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL lin12_mode: got %b expected 00", mode); end
    step();
    checks++; if (pwm_l !== 32'd0) begin errors++; $display("FAIL lin12_pwm: got %0d expected 0", pwm_l); end
    lin = 32'hFFFF_FFFF;
    step();
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL lin_max_mode: got %b expected 00", mode); end
    lin = 32'd4;
    step();
    checks++; if (mode !== 2'b10) begin errors++; $display("FAIL lin4_mode: got %b expected 10", mode); end
  endtask

  task automatic test_en_low();
    en = 1'b0; lin = 32'd3;
    step();
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL en_low_mode: got %b expected 00", mode); end
    step();
    checks++; if (pwm_l !== 32'd0) begin errors++; $display("FAIL en_low_pwm: got %0d expected 0", pwm_l); end
    en = 1'b1;
    step();
    checks++; if (mode !== 2'b01) begin errors++; $display("FAIL en_high_mode: got %b expected 01", mode); end
    step();
    checks++; if (pwm_l !== 32'd200) begin errors++; $display("FAIL en_high_pwm_l: got %0d expected 200", pwm_l); end
    checks++; if (pwm_r !== 32'd185) begin errors++; $display("FAIL en_high_pwm_r: got %0d expected 185", pwm_r); end
  endtask

  task automatic test_reset_priority();
    lin = '0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (pwm_l !== 32'd0) begin errors++; $display("FAIL rstp_pwm_l: got %0d expected 0", pwm_l); end
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL rstp_mode: got %b expected 00", mode); end
    checks++; if (settled !== 1'b1) begin errors++; $display("FAIL rstp_settled: got %b expected 1", settled); end
    step();
    checks++; if (mode !== 2'b10) begin errors++; $display("FAIL rstp_first_mode: got %b expected 10", mode); end
    step();
    checks++; if (pwm_l !== 32'd550) begin errors++; $display("FAIL rstp_recover: got %0d expected 550", pwm_l); end
  endtask
`endif

  // ------------------------------------------------------------------ sequence
  initial begin
    rst = 1'b1; en = 1'b0; lin = '0; sw_l_val = '0; sw_r_val = '0;
    test_reset();
`ifdef SPEED_RAMP_EN
    test_ramp_up();
    test_ramp_slow();
    test_ramp_halt();
    test_en_low();
    test_reset_mid_ramp();
`else
    test_fast();
    test_slow();
    test_retrim();
    test_halt_boundary();
    test_en_low();
    test_reset_priority();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/speed_ramp_ctrl.md
SPEED_RAMP_CTRL -- requirements
Module: speed_ramp_ctrl

Interface
REQ-001 SHALL have parameter PWM_W, default 32, meaning the width of the wheel speed outputs.
REQ-002 SHALL have parameter SEG_W, default 32, meaning the width of the line-count input.
REQ-003 SHALL have parameter FAST_BASE, default 500, meaning the full-speed base value.
REQ-004 SHALL have parameter SLOW_BASE, default 150, meaning the reduced-speed base value.
REQ-005 SHALL have parameter TRIM_GAIN, default 5, meaning the multiplier applied to the switch trim.
REQ-006 SHALL have parameters SLOW_SEG_A = 3 and SLOW_SEG_B = 9, meaning the line counts that select slow mode.
REQ-007 SHALL have parameter END_SEG, default 12, meaning the first line count that selects halt.
REQ-008 SHALL have parameters RAMP_STEP = 50 and TICK_DIV = 4, meaning the maximum output change per tick and the number of clocks per tick (at least 1).
REQ-009 Port clk, input, 1 bit: the single clock for the block.
REQ-010 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-011 Port en, input, 1 bit: drive enable; when low, the targets are forced to 0.
REQ-012 Port lin, input, SEG_W bits: count of black lines passed.
REQ-013 Ports sw_l_val and sw_r_val, input, 5 bits each: left and right trim.
REQ-014 Ports pwm_l and pwm_r, output, PWM_W bits each: registered wheel speeds.
REQ-015 Port mode, output, 2 bits: registered mode; 00 = HALT, 01 = SLOW, 10 = FAST; 11 is never driven.
REQ-016 Port settled, output, 1 bit: high when pwm_l equals target_l and pwm_r equals target_r.

Function
REQ-017 The mode register SHALL update every clock from lin and en, with the following priority:
- en = 0 -> HALT;
- lin >= END_SEG -> HALT;
- lin == SLOW_SEG_A or lin == SLOW_SEG_B -> SLOW;
- otherwise -> FAST.
REQ-018 The targets SHALL be computed combinationally from the mode register:
- FAST: FAST_BASE + sw_x_val*TRIM_GAIN;
- SLOW: SLOW_BASE + sw_x_val*TRIM_GAIN;
- HALT: 0.
REQ-019 The trim arithmetic SHALL be carried out at PWM_W width; the parameters are constrained so that FAST_BASE + 31*TRIM_GAIN < 2^PWM_W, so no overflow handling is required.
REQ-020 The tick counter SHALL count 0..TICK_DIV-1 and wrap; tick is asserted in the cycle where the count equals TICK_DIV-1 (every cycle when TICK_DIV = 1).
REQ-021 On tick, each pwm_x SHALL move toward target_x:
- if |target_x - pwm_x| <= RAMP_STEP, pwm_x loads target_x;
- otherwise pwm_x increases or decreases by exactly RAMP_STEP.
REQ-022 pwm_x SHALL never overshoot target_x and SHALL never underflow below 0.
REQ-023 Between ticks, pwm_x SHALL hold its value.
REQ-024 A target change mid-ramp SHALL take effect at the next tick, with no restart of the tick counter.
REQ-025 Both wheels SHALL ramp independently on the same tick.
REQ-026 settled SHALL be a combinational compare of the pwm registers against the current targets.
REQ-027 An unchanged mode with a changed trim SHALL retarget without any mode transition.

Reset
REQ-028 When rst = 1 at a clock edge, the block SHALL set pwm_l = 0, pwm_r = 0, mode = HALT and tick counter = 0; settled is therefore 1.
REQ-029 Reset SHALL take priority over tick, en and lin, including when asserted mid-ramp.
REQ-030 The first mode update after rst deasserts SHALL occur at the next clock edge.

Configuration
REQ-031 With macro SPEED_RAMP_EN defined, the block SHALL slew-limit the outputs exactly as specified in REQ-020 to REQ-024.
REQ-032 With SPEED_RAMP_EN undefined, the block SHALL remove the tick counter and load pwm_x = target_x on every clock.
- Latency: lin change to pwm change is 2 clocks.
- settled is 1 from the second clock after any input change.

Verification
REQ-033 Reset, then en = 1, lin = 0, sw_l_val = 2, sw_r_val = 0 -> mode = FAST; pwm_l steps 50 per 4 clocks and reaches 510 at tick 11; pwm_r reaches 500 at tick 10; settled rises after the tick on which pwm_l reaches 510.
REQ-034 From settled FAST with trims 0, set lin = 3 -> mode = SLOW next clock; pwm steps 500 -> 450 -> ... -> 150 over 7 ticks; settled = 0 until the 7th tick.
REQ-035 lin = 12 from SLOW at 150 -> mode = HALT; pwm reaches 0 at tick 3 with no underflow; lin = 9 instead -> stays SLOW.
REQ-036 en driven low at pwm = 300 mid-ramp-up -> mode = HALT next clock; pwm decreases 250, 200, ..., 0 on successive ticks.
REQ-037 rst pulsed for one clock at pwm_l = 350 -> next edge pwm_l = 0, mode = HALT, tick counter = 0; ramp restarts from 0 afterwards.
REQ-038 Built without SPEED_RAMP_EN, lin = 0 and sw = 31/31 -> pwm_l = pwm_r = 655 two clocks after lin is applied; lin = 9 -> 305 two clocks later.
